frv_dmem_responder: RTL

FRV_DMEM_RESPONDER -- requirements
Module: frv_dmem_responder

---
 rtl/frv_dmem_responder_if.sv | 23 ++
 rtl/frv_dmem_responder.sv | 103 ++++++++++
 2 files changed

// File: rtl/frv_dmem_responder_if.sv
// rtl/frv_dmem_responder_if.sv - data memory request/response bus between initiator and responder
interface frv_dmem_responder_if;
  logic        dmem_req;
  logic        dmem_wen;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_addr;
  logic        dmem_gnt;
  logic        dmem_recv;
  logic        dmem_ack;
  logic        dmem_error;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_wen, dmem_strb, dmem_wdata, dmem_addr, dmem_ack,
    input  dmem_gnt, dmem_recv, dmem_error, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_wen, dmem_strb, dmem_wdata, dmem_addr, dmem_ack,
    output dmem_gnt, dmem_recv, dmem_error, dmem_rdata
  );
endinterface

// File: rtl/frv_dmem_responder.sv
// rtl/frv_dmem_responder.sv - word memory responder with a 2-entry in-order response queue
// Range/alignment error checking is built only when FRV_DMEM_RESPONDER_ERRCHK_EN is defined.
module frv_dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input logic                 g_clk,
  input logic                 g_resetn,
  frv_dmem_responder_if.slave dmem
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [2:0]  CNT_LOAD = 3'(LATENCY - 1);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [1:0][31:0] q_rdata;
  logic [1:0][2:0]  q_cnt;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic [31:0]      offset;
  logic [AW-1:0]    word_idx;
  logic [31:0]      wmask;
  logic [31:0]      rd_val;
  logic             accept;
  logic             retire;
  logic             req_err;

  assign offset   = dmem.dmem_addr - BASE_ADDR;
  assign word_idx = offset[AW+1:2];
  assign wmask    = {{8{dmem.dmem_strb[3]}}, {8{dmem.dmem_strb[2]}},
                     {8{dmem.dmem_strb[1]}}, {8{dmem.dmem_strb[0]}}};

  // Grant only looks at occupancy, never at ack, so a full queue always stalls.
  assign dmem.dmem_gnt   = g_resetn && dmem.dmem_req && (count != 2'd2);
  assign dmem.dmem_recv  = (count != 2'd0) && (q_cnt[rd_ptr] == 3'd0);
  assign dmem.dmem_rdata = dmem.dmem_recv ? q_rdata[rd_ptr] : 32'd0;

  assign accept = dmem.dmem_gnt;
  assign retire = dmem.dmem_recv && dmem.dmem_ack;
  assign rd_val = (dmem.dmem_wen || req_err) ? 32'd0 : mem[word_idx];

`ifdef FRV_DMEM_RESPONDER_ERRCHK_EN
  logic [1:0] q_error;

  assign req_err = ((offset >> (AW + 2)) != 32'd0) ||
                   ((dmem.dmem_addr[1:0] != 2'b00) && (dmem.dmem_strb == 4'b1111));

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      q_error <= 2'b00;
    end else if (accept) begin
      q_error[wr_ptr] <= req_err;
    end
  end

  assign dmem.dmem_error = dmem.dmem_recv && q_error[rd_ptr];
`else
  assign req_err         = 1'b0;
  assign dmem.dmem_error = 1'b0;
  wire unused_offset     = &{1'b0, offset[31:AW+2], offset[1:0]};
`endif

  // Memory contents survive reset on purpose.
  always_ff @(posedge g_clk) begin
    if (accept && dmem.dmem_wen && !req_err) begin
      mem[word_idx] <= (mem[word_idx] & ~wmask) | (dmem.dmem_wdata & wmask);
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      q_rdata <= '0;
      q_cnt   <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      // Every entry ages on its own so a queued second entry can already be ready.
      for (int i = 0; i < 2; i++) begin
        if (q_cnt[i] != 3'd0) begin
          q_cnt[i] <= q_cnt[i] - 3'd1;
        end
      end
      if (accept) begin
        q_cnt[wr_ptr]   <= CNT_LOAD;
        q_rdata[wr_ptr] <= rd_val;
        wr_ptr          <= ~wr_ptr;
      end
      if (retire) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({accept, retire})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
